// File: rtl/prog_mem_pkg.sv
// Shared definitions for the 8-bit RISC CPU program memory and its readback engine.
// Holds memory geometry, the dumper FSM state type and the address-wrap helper
// that the CPU program counter also uses.
package prog_mem_pkg;

  localparam int PM_ADDR_WIDTH = 5;
  localparam int PM_DATA_WIDTH = 8;
  localparam int PM_DEPTH      = 1 << PM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

  // Next sequential address, wrapping from the top word back to 0.
  function automatic logic [PM_ADDR_WIDTH-1:0] next_addr(input logic [PM_ADDR_WIDTH-1:0] a);
    if (a == PM_ADDR_WIDTH'(PM_DEPTH - 1)) begin
      return '0;
    end
    return a + PM_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/prog_mem_dumper.sv
// Program memory readback engine: streams an inclusive, wrapping address range
// out of the program memory, one byte per beat, while holding the CPU off memory.
// Latency: start -> first dout_valid 3 cycles; 3 cycles per beat with dout_ready high.
// Backpressure: dout_ready low freezes SEND with all stream outputs stable; no re-read.
// Ports:
//   clock, reset             - rising-edge clock, synchronous active-high reset
//   start/first_addr/last_addr - dump request and inclusive range, sampled in IDLE only
//   rd_en/rd_addr/rd_data    - memory read port, data returns one cycle after rd_en
//   dout/dout_addr/dout_last/dout_valid/dout_ready - output byte stream
//   busy/hold_cpu/done       - status; done pulses once after the final beat transfers
module prog_mem_dumper
  import prog_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = PM_ADDR_WIDTH,
  parameter int DATA_WIDTH = PM_DATA_WIDTH,
  parameter int DEPTH      = PM_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] dout_addr,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  hold_cpu,
  output logic                  done
);

  dump_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_end;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [ADDR_WIDTH-1:0] r_dout_addr;
  logic                  r_dout_last;
  logic                  r_dout_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_cur_next;
  logic                  w_xfer;

  // Modulo-DEPTH increment so a range may wrap through the top word to 0.
  assign w_cur_next = (r_cur == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_cur + ADDR_WIDTH'(1);
  assign w_xfer     = r_dout_valid && dout_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cur        <= '0;
      r_end        <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_dout       <= '0;
      r_dout_addr  <= '0;
      r_dout_last  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Strobes default low; each state raises them for exactly one cycle.
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur     <= first_addr;
            r_end     <= last_addr;
            r_rd_en   <= 1'b1;
            r_rd_addr <= first_addr;
            r_busy    <= 1'b1;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          // rd_en is already high this cycle; memory returns data next cycle.
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_dout       <= rd_data;
          r_dout_addr  <= r_cur;
          r_dout_last  <= (r_cur == r_end);
          r_dout_valid <= 1'b1;
          r_state      <= ST_SEND;
        end
        ST_SEND: begin
          // The beat is held in the output registers, so a stall never re-reads.
          if (w_xfer) begin
            r_dout_valid <= 1'b0;
            if (r_dout_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cur     <= w_cur_next;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_cur_next;
              r_state   <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign dout       = r_dout;
  assign dout_addr  = r_dout_addr;
  assign dout_last  = r_dout_last;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign hold_cpu   = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_prog_mem_dumper.sv
// Bench for prog_mem_dumper: a behavioural program memory plus a reference model
// that derives each dump's expected beats from the range and memory contents.
module tb_prog_mem_dumper;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] first_addr;
  logic [4:0] last_addr;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] dout;
  logic [4:0] dout_addr;
  logic       dout_last;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       hold_cpu;
  logic       done;

  logic [7:0] mem [32];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  prog_mem_dumper dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .hold_cpu   (hold_cpu),
    .done       (done)
  );

  // Synchronous-read program memory.
  initial rd_data = 8'h00;
  always @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready always high, 1: random ready, 2: 5-cycle stall on the beat at 0x1B
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit mid_start, input bit reset_in_send);
    int n;
    int beat;
    int stall;
    bit held;
    bit fin;
    bit rdy;
    logic [7:0] hd;
    logic [4:0] ha;
    logic       hl;
    logic [4:0] ea;
    n     = ((int'(l) - int'(f)) % 32 + 32) % 32 + 1;
    beat  = 0;
    stall = 0;
    held  = 0;
    fin   = 0;
    hd = '0; ha = '0; hl = 1'b0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    dout_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 800 && !fin; c++) begin
      check("hold_eq_busy", hold_cpu, busy);
      if (c == 1) begin
        check("busy_k1", busy, 1);
        check("rd_en_k1", rd_en, 1);
        check("rd_addr_k1", rd_addr, f);
      end
      if (mode == 0 && c == 2) check("valid_k2", dout_valid, 0);
      if (mode == 0 && c == 3) check("valid_k3", dout_valid, 1);
      if (dout_valid && rd_en) check("rd_en_in_send", 1, 0);
      if (held) begin
        check("stall_valid", dout_valid, 1);
        check("stall_dout", dout, hd);
        check("stall_addr", dout_addr, ha);
        check("stall_last", dout_last, hl);
      end
      if (done) begin
        check("done_beats", beat, n);
        if (mode == 0) check("done_cycle", c, 3 * n + 1);
        if (mode == 2) check("stall_len", stall, 5);
        check("busy_in_done", busy, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("hold_after_done", hold_cpu, 0);
        fin = 1;
      end else begin
        check("busy_running", busy, 1);
        if (reset_in_send && dout_valid && beat == 1) begin
          dout_ready = 1'b0;
          reset = 1'b1;
          tick();
          reset = 1'b0;
          check("rst_valid", dout_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_hold", hold_cpu, 0);
          check("rst_done", done, 0);
          check("rst_rd_en", rd_en, 0);
          tick();
          check("rst_no_done", done, 0);
          check("rst_idle", busy, 0);
          fin = 1;
        end else begin
          if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
          else if (mode == 2 && dout_valid && dout_addr == 5'h1B && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else rdy = 1'b1;
          dout_ready = rdy;
          if (dout_valid && rdy) begin
            if (beat < n) begin
              ea = f + 5'(beat);
              check("beat_addr", dout_addr, ea);
              check("beat_data", dout, mem[ea]);
              check("beat_last", dout_last, (beat == n - 1));
            end else begin
              check("extra_beat", beat, n);
            end
            beat++;
            held = 0;
          end else if (dout_valid) begin
            held = 1;
            hd = dout; ha = dout_addr; hl = dout_last;
          end else begin
            held = 0;
          end
          if (mid_start && c == 7) begin
            start = 1'b1;
            first_addr = 5'h00;
          end else begin
            start = 1'b0;
            first_addr = f;
          end
          tick();
        end
      end
    end
    start = 1'b0;
    if (!fin) check("timeout", 0, 1);
  endtask

  initial begin
    logic [4:0] rf;
    logic [4:0] rl;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[5'h00] = 8'hFE;
    mem[5'h01] = 8'h00;
    mem[5'h03] = 8'hBA;
    mem[5'h1A] = 8'h00;
    mem[5'h1B] = 8'hFF;
    mem[5'h1C] = 8'hAA;
    mem[5'h1E] = 8'hE3;
    mem[5'h1F] = 8'h00;

    // Reset with start held high: reset must win.
    reset = 1'b1; start = 1'b1; first_addr = 5'h03; last_addr = 5'h05; dout_ready = 1'b1;
    tick();
    tick();
    check("rst_rd_en0", rd_en, 0);
    check("rst_rd_addr0", rd_addr, 0);
    check("rst_dout0", dout, 0);
    check("rst_dout_addr0", dout_addr, 0);
    check("rst_dout_last0", dout_last, 0);
    check("rst_dout_valid0", dout_valid, 0);
    check("rst_busy0", busy, 0);
    check("rst_hold0", hold_cpu, 0);
    check("rst_done0", done, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("idle_after_rst", busy, 0);

    run_dump(5'h00, 5'h1F, 0, 1'b0, 1'b0);   // full dump
    tick();
    run_dump(5'h1E, 5'h01, 0, 1'b1, 1'b0);   // wrap, with ignored start mid-dump
    tick();
    run_dump(5'h1A, 5'h1C, 2, 1'b0, 1'b0);   // backpressure on 0x1B
    tick();
    run_dump(5'h1B, 5'h1B, 0, 1'b0, 1'b0);   // single word
    tick();
    run_dump(5'h02, 5'h08, 0, 1'b0, 1'b1);   // reset in SEND
    run_dump(5'h03, 5'h09, 0, 1'b0, 1'b0);   // fresh start after reset
    for (int r = 0; r < 8; r++) begin
      rf = 5'($urandom);
      rl = 5'($urandom);
      tick();
      run_dump(rf, rl, 1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_mem_dumper.md
# prog_mem_dumper

Readback engine for the 32×8 program memory of the 8-bit RISC CPU. It is the reverse of the serial `Load`/`data_in` path, which writes one byte per clock into consecutive addresses. On a `start` command this block reads an inclusive address range back out of memory and presents it one byte at a time on a valid/ready stream. While it runs, it holds the CPU off the memory. It sits between the program memory read port and a debug/host stream sink.

## Interface
- `ADDR_WIDTH`, default 5: memory address width.
- `DATA_WIDTH`, default 8: memory word width.
- `DEPTH`, default 32: number of words, equal to 2**ADDR_WIDTH.

- `clock`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: dump request; sampled only in IDLE.
- `first_addr`, in, ADDR_WIDTH: first address of the range; latched on accepted `start`.
- `last_addr`, in, ADDR_WIDTH: last address of the range, inclusive; latched on accepted `start`.
- `rd_en`, out, 1: memory read strobe.
- `rd_addr`, out, ADDR_WIDTH: memory read address.
- `rd_data`, in, DATA_WIDTH: memory read data, valid one cycle after `rd_en`.
- `dout`, out, DATA_WIDTH: stream data.
- `dout_addr`, out, ADDR_WIDTH: address of `dout`.
- `dout_last`, out, 1: marks the final beat of the range.
- `dout_valid`, out, 1: stream valid.
- `dout_ready`, in, 1: stream ready.
- `busy`, out, 1: high in any state other than IDLE.
- `hold_cpu`, out, 1: equal to `busy`; the CPU must not fetch or write memory while it is high.
- `done`, out, 1: one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - On `start`, latch `first_addr` into the current address `cur` and `last_addr` into `end`.
  - Go to READ.
  - `start` is ignored in every other state.
- READ: `rd_en`=1, `rd_addr`=`cur`. Go to WAIT.
- WAIT:
  - Register `rd_data` into `dout`, `cur` into `dout_addr`, and (`cur`==`end`) into `dout_last`.
  - Go to SEND.
- SEND:
  - `dout_valid`=1, with `dout`, `dout_addr` and `dout_last` held stable.
  - When `dout_valid`&&`dout_ready` at a rising edge (a transfer):
    - If `dout_last`, go to DONE.
    - Otherwise set `cur`←`cur`+1 mod DEPTH and go to READ.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Address arithmetic is modulo DEPTH: 31+1 wraps to 0.
- Beat count is ((`last_addr` − `first_addr`) mod DEPTH) + 1:
  - `first_addr`==`last_addr` gives 1 beat.
  - 0→31 gives 32 beats.
  - 1→0 gives 32 beats, wrapping through 31→0.
- `rd_en` is never asserted in SEND; the block never re-reads under backpressure.
- The block never writes memory.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `dout`=0, `dout_addr`=0, `dout_last`=0, `dout_valid`=0, `busy`=0, `hold_cpu`=0, `done`=0, state IDLE.
- `start` sampled high at edge k:
  - `busy` and `hold_cpu` are high from k+1.
  - `rd_en` is high during cycle k+1.
  - `dout_valid` is first high in cycle k+3.
- With `dout_ready` held high, one beat completes every 3 cycles.
  - An N-beat dump asserts `done` in cycle k+3N+1.
  - `busy` falls at edge k+3N+2.
- `dout_ready` low: SEND persists and all stream outputs stay stable. No timeout.
- `dout_valid` may be high while `dout_ready` is low. `dout_valid` drops only after a transfer or on reset.
- `reset` at any point, including mid-SEND, gives reset values on the next cycle:
  - The pending beat is discarded with no transfer.
  - No `done` pulse.
  - `hold_cpu` is released.
- `start` and `reset` high together: reset wins.

## Structure
- Shared package `prog_mem_pkg` holds:
  - ADDR_WIDTH and DATA_WIDTH, shared with CPU and memory.
  - The dumper state enum.
  - A `next_addr` wrap function, reused by the CPU's program counter.
- No sub-module is needed: a single FSM with the address and output registers.

## Test plan
Memory is preloaded with the CPU self-test program: 0x00=0xFE, 0x03=0xBA, 0x1A=0x00, 0x1B=0xFF, 0x1C=0xAA, 0x1E=0xE3, 0x1F=0x00, and the remaining locations as loaded by the standard load sequence.

1. Reset: assert `reset` for 2 cycles with `start`=1 held → all outputs 0, `busy`=0, no `rd_en`.
2. Full dump, `first_addr`=0, `last_addr`=31, `dout_ready`=1 →
   - 32 beats, `dout_addr` 0..31 in order.
   - Beat 0 is 0xFE, beat 0x1E is 0xE3.
   - `dout_last` is set only on addr 31.
   - `done` in cycle k+97; `hold_cpu` high throughout.
3. Wrap, `first_addr`=0x1E, `last_addr`=0x01 → 4 beats:
   - addrs 1E, 1F, 00, 01.
   - data E3, 00, FE, then the 0x01 content (0x00).
   - `dout_last` on the beat at addr 01.
4. Backpressure, range 0x1A..0x1C, `dout_ready` low 5 cycles on beat 0x1B →
   - `dout`=0xFF held stable with `dout_valid`=1.
   - No `rd_en` during the stall.
   - Beats 00, FF, AA in order.
5. Single word, `first_addr`=`last_addr`=0x1B → one beat 0xFF with `dout_last`=1; `done` at k+4.
6. Disturbances:
   - Pulse `start` with `first_addr`=0 mid-dump → ignored; the sequence is unchanged.
   - Assert `reset` in SEND → next cycle `dout_valid`=0, `busy`=0, no `done`.
   - A fresh `start` then dumps correctly.
